// File: rtl/param_counter.sv
// Modulo-N up/down counter with clear, clamped load, terminal count, wrap pulse and epoch count.
// Define PARAM_COUNTER_SAT_EN to make the counter saturate at its limits instead of wrapping.
module param_counter #(
    parameter int     WIDTH   = 4,
    parameter longint MODULUS = 10,
    parameter int     EPOCH_W = 8
) (
    input  logic               iclk,
    input  logic               irst,
    input  logic               ien,
    input  logic               iup,
    input  logic               iclr,
    input  logic               iload,
    input  logic [WIDTH-1:0]   ildval,
    output logic [WIDTH-1:0]   ocnt,
    output logic               otc,
    output logic               owrap,
    output logic [EPOCH_W-1:0] oepoch
);

    if (WIDTH < 2 || WIDTH > 32 || MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_params
        $error("param_counter: illegal WIDTH/MODULUS combination");
    end

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

    // Load values beyond the count range are pulled down to the top count.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        return (v > MAXV) ? MAXV : v;
    endfunction

    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v, input logic up);
        return up ? v + 1'b1 : v - 1'b1;
    endfunction

    function automatic logic [WIDTH-1:0] wrap_target(input logic up);
        return up ? '0 : MAXV;
    endfunction

    // At the limit in the current direction; doubles as the wrap/saturation condition.
    assign otc = iup ? (ocnt == MAXV) : (ocnt == '0);

    always_ff @(posedge iclk) begin
        if (irst) begin
            ocnt   <= '0;
            owrap  <= 1'b0;
            oepoch <= '0;
        end else begin
            owrap <= 1'b0;
            if (iclr) begin
                ocnt <= '0;
            end else if (iload) begin
                ocnt <= clamp_load(ildval);
            end else if (ien) begin
                if (!otc) begin
                    ocnt <= step(ocnt, iup);
                end else begin
`ifdef PARAM_COUNTER_SAT_EN
                    ocnt <= ocnt;
`else
                    ocnt   <= wrap_target(iup);
                    owrap  <= 1'b1;
                    oepoch <= oepoch + 1'b1;
`endif
                end
            end
        end
    end

endmodule

// File: doc/param_counter.md
Name: param_counter

Overview:
- Parametrised successor to the team's fixed 4-bit free-running counter.
- Modulo-N up/down counter with enable, synchronous clear, parallel load, a terminal-count flag, a one-cycle wrap pulse and a wrap (epoch) counter.
- Used as the tap-index / sample-phase sequencer for the FIR datapath and the Booth multiplier step control.

Parameters:
- WIDTH, 4, bit width of ocnt; legal range 2..32.
- MODULUS, 10, count range 0..MODULUS-1; legal range 2..2^WIDTH (elaboration error otherwise).
- EPOCH_W, 8, width of the wrap counter oepoch.

Ports:
- iclk  in  1  clock; all logic on the rising edge.
- irst  in  1  reset, synchronous, active-high.
- ien  in  1  count enable.
- iup  in  1  direction: 1 = up, 0 = down.
- iclr  in  1  synchronous clear of ocnt only.
- iload  in  1  parallel load strobe.
- ildval  in  WIDTH  load value.
- ocnt  out  WIDTH  current count, registered.
- otc  out  1  terminal count flag, combinational from ocnt and iup.
- owrap  out  1  wrap pulse, registered.
- oepoch  out  EPOCH_W  number of wraps since reset, registered.

Behaviour:
- Reset: irst=1 at a rising edge sets ocnt=0, owrap=0 and oepoch=0. otc then follows its equation (1 if iup=0, since ocnt=0). irst overrides every other input.
- Priority per edge: irst > iclr > iload > ien. Only the winning action occurs.
- iclr: ocnt <= 0. No wrap. oepoch unchanged. owrap <= 0.
- iload: ocnt <= ildval if ildval <= MODULUS-1, else ocnt <= MODULUS-1 (clamp). No wrap. owrap <= 0.
- ien=1, iup=1: if ocnt == MODULUS-1 then ocnt <= 0 and wrap; else ocnt <= ocnt+1.
- ien=1, iup=0: if ocnt == 0 then ocnt <= MODULUS-1 and wrap; else ocnt <= ocnt-1.
- ien=0 with no other action: ocnt holds. owrap <= 0.
- Wrap event: owrap <= 1 for exactly one cycle, the cycle in which ocnt shows the wrapped value. oepoch <= oepoch+1 modulo 2^EPOCH_W (rolls over silently).
- Back-to-back wraps with MODULUS=2: owrap may stay high on consecutive cycles, and each wrap counts once.
- otc = (iup & ocnt==MODULUS-1) | (~iup & ocnt==0). Pure combinational, so toggling iup changes otc in the same cycle.
- Direction change mid-count takes effect on the next enabled edge. No extra latency, no glitch on ocnt.
- Reset mid-count: takes effect at the next edge regardless of ien, iload or iclr.
- Arithmetic: compare and increment at WIDTH bits. No intermediate overflow, because ocnt is never above MODULUS-1.

Optional Feature:
- Macro: PARAM_COUNTER_SAT_EN.
- Defined: saturating mode. With iup=1, ien=1 and ocnt==MODULUS-1, ocnt holds. With iup=0, ien=1 and ocnt==0, ocnt holds. owrap stays 0 and oepoch stays 0 permanently. otc behaves as above, signalling saturation.
- Not defined: modulo wrap behaviour as specified in Behaviour.

Test Plan:
1. Reset then count up (WIDTH=4, MODULUS=10): irst=1 for 10 cycles, then ien=1, iup=1 for 25 cycles -> ocnt 0,1..9,0,1..9,0..4. owrap high exactly the cycle ocnt returns to 0 (twice). oepoch=2 at the end. otc=1 whenever ocnt=9.
2. Count down: load 3, then ien=1, iup=0 -> ocnt 3,2,1,0,9,8. owrap=1 on the cycle ocnt=9. otc=1 at ocnt=0.
3. Load clamp and priority: iload=1, ildval=13 -> ocnt=9. iclr=1 and iload=1 together with ildval=5 -> ocnt=0. irst with iclr, iload and ien all high -> ocnt=0 and oepoch=0.
4. Mid-run control: count up to 6, drop ien for 3 cycles -> ocnt holds 6 and owrap=0. Toggle iup=0 -> otc=0 immediately and the next count is 5. Assert irst at ocnt=5 -> ocnt=0 at the next edge.
5. Epoch rollover: EPOCH_W=2, MODULUS=2, up count for 10 cycles -> owrap high every other cycle. oepoch follows 0,1,2,3,0,1.
6. With PARAM_COUNTER_SAT_EN defined: up count for 15 cycles -> ocnt stops at 9, owrap never asserts, oepoch=0. Then iup=0 for 12 cycles -> ocnt stops at 0.
